rf_writeback: RTL

- Writer side of the GPR file: produces the single write port (regwrite, writereg, writedata) consumed by the register file at posedge clk.
- Merges two result sources:
  - main pipeline MEM/WB results, including load byte/half extraction;
  - a long-latency (LL) channel from the multi-cycle mult/div unit, buffered in a small FIFO.
- Owns arbitration, $zero suppression and anti-starvation stall generation.

---
 rtl/mips_wb_pkg.sv | 22 ++
 rtl/wb_ll_fifo.sv | 92 +++++++++
 rtl/rf_writeback.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the GPR writeback path: load-type encodings,
// register/data widths and the long-latency result entry.
package mips_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

  typedef enum logic [2:0] {
    LDT_LW  = 3'd0,
    LDT_LB  = 3'd1,
    LDT_LBU = 3'd2,
    LDT_LH  = 3'd3,
    LDT_LHU = 3'd4
  } ldtype_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;
  } ll_entry_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// Small synchronous FIFO for long-latency results. Wrap-bit pointers decide full/empty.
// With RF_WB_PENDING_EN it also exposes next-state per-entry valid bits and destinations.
module wb_ll_fifo
  import mips_wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  ll_entry_t push_data_i,
  input  logic      pop_i,
  output logic      ready_o,
  output logic      empty_o,
`ifdef RF_WB_PENDING_EN
  output logic [Depth-1:0]                 ent_valid_o,
  output logic [Depth-1:0][REG_ADDR_W-1:0] ent_dst_o,
`endif
  output ll_entry_t head_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ll_entry_t   mem_q [Depth];
  ll_entry_t   mem_d [Depth];
  logic        ready_q, ready_d;
  logic        full, do_push, do_pop;

  function automatic logic is_full(input logic [AW:0] wr, input logic [AW:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  assign full    = is_full(wr_ptr_q, rd_ptr_q);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign ready_o = ready_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
    end
    // Ready is a flop so the LL producer never sees a path from its own valid.
    ready_d = !is_full(wr_ptr_d, rd_ptr_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      mem_q    <= mem_d;
    end
  end

`ifdef RF_WB_PENDING_EN
  logic [Depth-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (do_pop) begin
      valid_d[rd_ptr_q[AW-1:0]] = 1'b0;
    end
    if (do_push) begin
      valid_d[wr_ptr_q[AW-1:0]] = 1'b1;
    end
    for (int unsigned i = 0; i < Depth; i++) begin
      ent_dst_o[i] = mem_d[i].dst;
    end
  end

  assign ent_valid_o = valid_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end
`endif

endmodule

// File: rtl/rf_writeback.sv
// GPR write-port driver: merges MEM/WB results with a buffered long-latency channel,
// with anti-starvation stalls. RF_WB_PENDING_EN adds the registered pending_mask output.
module rf_writeback
  import mips_wb_pkg::*;
#(
  parameter int unsigned LL_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_dst,
  input  logic [DATA_W-1:0]     pipe_result,
  input  logic                  pipe_memtoreg,
  input  logic [DATA_W-1:0]     pipe_memdata,
  input  logic [2:0]            pipe_ldtype,
  input  logic [1:0]            pipe_addr_lo,
  output logic                  pipe_stall,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_dst,
  input  logic [DATA_W-1:0]     ll_data,
`ifdef RF_WB_PENDING_EN
  output logic [NUM_REGS-1:0]   pending_mask,
`endif
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0]     writedata
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  ll_entry_t             ll_in, ll_head;
  logic                  ll_push, ll_pop, ll_empty;
  logic [CntW-1:0]       starve_q, starve_d;
  logic                  starve_max;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] writereg_q, writereg_d;
  logic [DATA_W-1:0]     writedata_q, writedata_d;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_W-1:0]     load_data;

  assign ll_in   = '{dst: ll_dst, data: ll_data};
  assign ll_push = ll_valid && ll_ready;

`ifdef RF_WB_PENDING_EN
  logic [LL_DEPTH-1:0]                 ent_valid;
  logic [LL_DEPTH-1:0][REG_ADDR_W-1:0] ent_dst;
  logic [NUM_REGS-1:0]                 pending_q, pending_d;
`endif

  wb_ll_fifo #(
    .Depth(LL_DEPTH)
  ) u_ll_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (ll_push),
    .push_data_i(ll_in),
    .pop_i      (ll_pop),
    .ready_o    (ll_ready),
    .empty_o    (ll_empty),
`ifdef RF_WB_PENDING_EN
    .ent_valid_o(ent_valid),
    .ent_dst_o  (ent_dst),
`endif
    .head_o     (ll_head)
  );

  // Big-endian lanes: lane 0 is the most significant byte.
  always_comb begin
    unique case (pipe_addr_lo)
      2'd0:    ld_byte = pipe_memdata[31:24];
      2'd1:    ld_byte = pipe_memdata[23:16];
      2'd2:    ld_byte = pipe_memdata[15:8];
      default: ld_byte = pipe_memdata[7:0];
    endcase
    ld_half = pipe_addr_lo[1] ? pipe_memdata[15:0] : pipe_memdata[31:16];
    case (pipe_ldtype)
      LDT_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
      LDT_LBU: load_data = {24'd0, ld_byte};
      LDT_LH:  load_data = {{16{ld_half[15]}}, ld_half};
      LDT_LHU: load_data = {16'd0, ld_half};
      default: load_data = pipe_memdata;
    endcase
  end

  always_comb begin
    starve_max  = (starve_q == CntW'(STARVE_MAX));
    pipe_stall  = starve_max && !ll_empty;
    ll_pop      = !ll_empty && (pipe_stall || !pipe_valid);
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (ll_pop) begin
      regwrite_d  = (ll_head.dst != '0);
      writereg_d  = ll_head.dst;
      writedata_d = ll_head.data;
    end else if (pipe_valid) begin
      regwrite_d  = (pipe_dst != '0);
      writereg_d  = pipe_dst;
      writedata_d = pipe_memtoreg ? load_data : pipe_result;
    end
    if (ll_empty || ll_pop) begin
      starve_d = '0;
    end else if (!starve_max) begin
      starve_d = starve_q + CntW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  assign regwrite  = regwrite_q;
  assign writereg  = writereg_q;
  assign writedata = writedata_q;

`ifdef RF_WB_PENDING_EN
  always_comb begin
    pending_d = '0;
    for (int unsigned i = 0; i < LL_DEPTH; i++) begin
      if (ent_valid[i]) begin
        pending_d[ent_dst[i]] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_mask = pending_q;
`endif

endmodule
